// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared constants for the SAP-1 controller-sequencer.
//   - Opcode constants (IR[7:4]).
//   - Step encoding T0..T4 and HALTED.
//   - Bit positions of each strobe inside the control word.
//   - last_step_of(): final T-state of each opcode.
// -----------------------------------------------------------------------------
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        HALTED = 3'd5
    } step_t;

    // Control word bit indices
    localparam int CW_PC_ENABLE   = 0;
    localparam int CW_PC_INC      = 1;
    localparam int CW_PC_LOAD     = 2;
    localparam int CW_MAR_IN      = 3;
    localparam int CW_RAM_IN      = 4;
    localparam int CW_RAM_OUT     = 5;
    localparam int CW_IR_LATCH    = 6;
    localparam int CW_IR_ENABLE   = 7;
    localparam int CW_A_LATCH     = 8;
    localparam int CW_A_ENABLE    = 9;
    localparam int CW_B_LATCH     = 10;
    localparam int CW_ALU_ENABLE  = 11;
    localparam int CW_ALU_SUB     = 12;
    localparam int CW_FLAGS_LATCH = 13;
    localparam int CW_OUT_LATCH   = 14;
    localparam int CW_WIDTH       = 15;

    // Final T-state of each instruction; NOPs end after fetch. HLT reports T2
    // so that a mid-instruction change to HLT beyond T2 still returns to T0.
    function automatic step_t last_step_of(input logic [3:0] op);
        step_t last_v;
        case (op)
            OP_LDA, OP_STA:                    last_v = T3;
            OP_ADD, OP_SUB:                    last_v = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                    last_v = T2;
            default:                           last_v = T1;
        endcase
        return last_v;
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// -----------------------------------------------------------------------------
// sap_microcode_rom
// Purely combinational microcode decode.
//   step      in  T-state from the sequencer
//   opcode    in  IR[7:4]
//   flag_c    in  latched ALU carry (JC condition)
//   flag_z    in  latched ALU zero  (JZ condition)
//   ctrl      out control word, bit positions from sap_pkg
//   last_step out current step is the final step of this instruction
// -----------------------------------------------------------------------------
module sap_microcode_rom
    import sap_pkg::*;
(
    input  step_t               step,
    input  logic [3:0]          opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CW_WIDTH-1:0] ctrl,
    output logic                last_step
);

    // Control word decode: fetch steps are opcode independent, execute steps
    // are selected by opcode. HALTED and illegal steps produce no strobes.
    always_comb begin
        ctrl = {CW_WIDTH{1'b0}};
        case (step)
            T0: begin
                ctrl[CW_PC_ENABLE] = 1'b1;
                ctrl[CW_MAR_IN]    = 1'b1;
            end
            T1: begin
                ctrl[CW_RAM_OUT]  = 1'b1;
                ctrl[CW_IR_LATCH] = 1'b1;
                ctrl[CW_PC_INC]   = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[CW_IR_ENABLE] = 1'b1;
                        ctrl[CW_MAR_IN]    = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl[CW_IR_ENABLE] = 1'b1;
                        ctrl[CW_A_LATCH]   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[CW_IR_ENABLE] = 1'b1;
                        ctrl[CW_PC_LOAD]   = 1'b1;
                    end
                    OP_JC, OP_JZ: begin
                        // Conditional jump: strobes only when the selected flag is set
                        if ((opcode == OP_JC) ? flag_c : flag_z) begin
                            ctrl[CW_IR_ENABLE] = 1'b1;
                            ctrl[CW_PC_LOAD]   = 1'b1;
                        end else begin
                            ctrl[CW_IR_ENABLE] = 1'b0;
                            ctrl[CW_PC_LOAD]   = 1'b0;
                        end
                    end
                    OP_OUT: begin
                        ctrl[CW_A_ENABLE]  = 1'b1;
                        ctrl[CW_OUT_LATCH] = 1'b1;
                    end
                    default: begin
                        ctrl = {CW_WIDTH{1'b0}};
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_A_LATCH] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_B_LATCH] = 1'b1;
                    end
                    OP_STA: begin
                        ctrl[CW_A_ENABLE] = 1'b1;
                        ctrl[CW_RAM_IN]   = 1'b1;
                    end
                    default: begin
                        ctrl = {CW_WIDTH{1'b0}};
                    end
                endcase
            end
            T4: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    ctrl[CW_ALU_ENABLE]  = 1'b1;
                    ctrl[CW_A_LATCH]     = 1'b1;
                    ctrl[CW_FLAGS_LATCH] = 1'b1;
                    ctrl[CW_ALU_SUB]     = (opcode == OP_SUB);
                end else begin
                    ctrl = {CW_WIDTH{1'b0}};
                end
            end
            default: begin
                ctrl = {CW_WIDTH{1'b0}};
            end
        endcase
    end

    // End-of-instruction detect; any step at or past the opcode's last step
    // ends it, so an opcode change mid-instruction can never strand the sequencer.
    always_comb begin
        last_step = 1'b0;
        if (step == HALTED) begin
            last_step = 1'b0;
        end else begin
            last_step = (step >= last_step_of(opcode));
        end
    end

endmodule

// File: rtl/sap_controller.sv
// -----------------------------------------------------------------------------
// sap_controller
// SAP-1 controller-sequencer: step register plus microcode decode driving all
// datapath strobes.
//   clk, reset        datapath clock, async active-high reset
//   opcode            IR[7:4], meaningful from T2
//   flag_c, flag_z    latched ALU flags
//   pc_enable .. out_latch  control strobes (combinational from step/opcode/flags)
//   halt              processor halted
//   step              current T-state (5 = HALTED)
// While reset is high every strobe is forced low so a mid-instruction reset
// abandons the instruction without waiting for a clock edge.
// -----------------------------------------------------------------------------
module sap_controller
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_enable,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_latch,
    output logic       ir_enable,
    output logic       a_latch,
    output logic       a_enable,
    output logic       b_latch,
    output logic       alu_enable,
    output logic       alu_sub,
    output logic       flags_latch,
    output logic       out_latch,
    output logic       halt,
    output logic [2:0] step
);

    step_t               step_r;
    logic [CW_WIDTH-1:0] rom_ctrl_s;
    logic [CW_WIDTH-1:0] ctrl_s;
    logic                last_s;

    sap_microcode_rom u_rom (
        .step      (step_r),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (rom_ctrl_s),
        .last_step (last_s)
    );

    // Step sequencer: advance, wrap to T0 after the last step, park in HALTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r <= T0;
        end else begin
            case (step_r)
                HALTED: begin
                    step_r <= HALTED;
                end
                T0, T1, T2, T3, T4: begin
                    if ((step_r == T2) && (opcode == OP_HLT)) begin
                        step_r <= HALTED;
                    end else if (last_s) begin
                        step_r <= T0;
                    end else begin
                        step_r <= step_t'(step_r + 3'd1);
                    end
                end
                default: begin
                    step_r <= T0;
                end
            endcase
        end
    end

    // Reset gating of the control word.
    always_comb begin
        ctrl_s = {CW_WIDTH{1'b0}};
        if (reset) begin
            ctrl_s = {CW_WIDTH{1'b0}};
        end else begin
            ctrl_s = rom_ctrl_s;
        end
    end

    assign pc_enable   = ctrl_s[CW_PC_ENABLE];
    assign pc_inc      = ctrl_s[CW_PC_INC];
    assign pc_load     = ctrl_s[CW_PC_LOAD];
    assign mar_in      = ctrl_s[CW_MAR_IN];
    assign ram_in      = ctrl_s[CW_RAM_IN];
    assign ram_out     = ctrl_s[CW_RAM_OUT];
    assign ir_latch    = ctrl_s[CW_IR_LATCH];
    assign ir_enable   = ctrl_s[CW_IR_ENABLE];
    assign a_latch     = ctrl_s[CW_A_LATCH];
    assign a_enable    = ctrl_s[CW_A_ENABLE];
    assign b_latch     = ctrl_s[CW_B_LATCH];
    assign alu_enable  = ctrl_s[CW_ALU_ENABLE];
    assign alu_sub     = ctrl_s[CW_ALU_SUB];
    assign flags_latch = ctrl_s[CW_FLAGS_LATCH];
    assign out_latch   = ctrl_s[CW_OUT_LATCH];

    assign halt = (!reset) && (step_r == HALTED);
    assign step = step_r;

endmodule
